// File: rtl/repeat_range_gen_pkg.sv
// Shared types, reset values and the range-membership test for repeat_range_gen.
// Config macro: REPEAT_RANGE_GEN_LAST_EN (see repeat_range_gen).
package repeat_range_gen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic RST_VALID = 1'b0;
    localparam logic RST_DONE  = 1'b1;
    localparam logic RST_LAST  = 1'b0;

    // Callers sign-extend into this width; supported WIDTH must stay below RR_MAX_W.
    localparam int RR_MAX_W = 128;

    function automatic logic in_range(input logic signed [RR_MAX_W:0] x,
                                      input logic signed [RR_MAX_W:0] lim,
                                      input logic signed [RR_MAX_W:0] stp);
        logic res;
        if (!stp[RR_MAX_W] && (stp != {(RR_MAX_W+1){1'b0}})) begin
            res = (x < lim);
        end else if (stp[RR_MAX_W]) begin
            res = (x > lim);
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/range_cursor.sv
// Range cursor: holds i plus captured limit/step and reports range status of the
// current/next value. With REPEAT_RANGE_GEN_LAST_EN it also looks two values ahead.
module range_cursor
    import repeat_range_gen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic                    advance_i,
    input  logic signed [WIDTH-1:0] base_i,
    input  logic signed [WIDTH-1:0] limit_i,
    input  logic signed [WIDTH-1:0] step_i,
    output logic signed [WIDTH-1:0] nxt_o,
    output logic                    cur_in_range_o,
    output logic                    nxt_in_range_o
`ifdef REPEAT_RANGE_GEN_LAST_EN
    ,
    output logic                    nxt2_in_range_o
`endif
);

    localparam int EW  = RR_MAX_W + 1;
    localparam int PAD = RR_MAX_W - WIDTH;

    logic signed [WIDTH-1:0] i_q, lim_q, step_q;
    logic signed [WIDTH-1:0] src_s, lim_s, stp_s;
    logic signed [WIDTH:0]   nxt_s;
    logic signed [EW-1:0]    src_e, lim_e, stp_e, nxt_e;

    // While loading, status refers to the incoming operands so start can judge emptiness.
    assign src_s = load_i ? base_i  : i_q;
    assign lim_s = load_i ? limit_i : lim_q;
    assign stp_s = load_i ? step_i  : step_q;

    assign nxt_s = {src_s[WIDTH-1], src_s} + {stp_s[WIDTH-1], stp_s};
    assign nxt_o = nxt_s[WIDTH-1:0];

    assign src_e = {{(PAD+1){src_s[WIDTH-1]}}, src_s};
    assign lim_e = {{(PAD+1){lim_s[WIDTH-1]}}, lim_s};
    assign stp_e = {{(PAD+1){stp_s[WIDTH-1]}}, stp_s};
    assign nxt_e = {{PAD{nxt_s[WIDTH]}}, nxt_s};

    assign cur_in_range_o = in_range(src_e, lim_e, stp_e);
    assign nxt_in_range_o = (nxt_s[WIDTH] == nxt_s[WIDTH-1]) && in_range(nxt_e, lim_e, stp_e);

`ifdef REPEAT_RANGE_GEN_LAST_EN
    logic signed [WIDTH:0] nxt2_s;
    logic signed [EW-1:0]  nxt2_e;

    assign nxt2_s = {nxt_o[WIDTH-1], nxt_o} + {stp_s[WIDTH-1], stp_s};
    assign nxt2_e = {{PAD{nxt2_s[WIDTH]}}, nxt2_s};
    assign nxt2_in_range_o = (nxt2_s[WIDTH] == nxt2_s[WIDTH-1]) && in_range(nxt2_e, lim_e, stp_e);
`endif

    // Cursor and captured bounds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            i_q    <= {WIDTH{1'b0}};
            lim_q  <= {WIDTH{1'b0}};
            step_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            i_q    <= base_i;
            lim_q  <= limit_i;
            step_q <= step_i;
        end else if (advance_i) begin
            i_q    <= nxt_o;
        end else begin
            i_q    <= i_q;
        end
    end

endmodule

// File: rtl/repeat_range_gen.sv
// Generator for range(base, limit, step) yielding each value reps times, with
// start/ready/valid/done handshake. Define REPEAT_RANGE_GEN_LAST_EN to add _last.
module repeat_range_gen
    import repeat_range_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REP_W = 8
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    input  logic        [REP_W-1:0] reps,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [WIDTH-1:0] _0,
    output logic        [REP_W-1:0] _1
`ifdef REPEAT_RANGE_GEN_LAST_EN
    ,
    output logic                    _last
`endif
);

    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [REP_W-1:0]        r_q, r_d, reps_q, reps_d, idx_q, idx_d;
    logic signed [WIDTH-1:0] val_q, val_d, nxt_s;
    logic                    valid_q, valid_d, done_q, done_d;
    logic                    load_s, advance_s, xfer_s, last_rep_s, start_ok_s;
    logic                    cur_ok_s, nxt_ok_s;

    assign xfer_s     = valid_q && _ready;
    assign last_rep_s = (r_q == (reps_q - REP_ONE));
    assign start_ok_s = (reps != REP_ZERO) && cur_ok_s;

`ifdef REPEAT_RANGE_GEN_LAST_EN
    logic nxt2_ok_s, last_q, last_d;
`endif

    range_cursor #(.WIDTH(WIDTH)) u_cursor (
        .clk_i          (_clock),
        .rst_i          (_reset),
        .load_i         (load_s),
        .advance_i      (advance_s),
        .base_i         (base),
        .limit_i        (limit),
        .step_i         (step),
        .nxt_o          (nxt_s),
        .cur_in_range_o (cur_ok_s),
        .nxt_in_range_o (nxt_ok_s)
`ifdef REPEAT_RANGE_GEN_LAST_EN
        ,
        .nxt2_in_range_o(nxt2_ok_s)
`endif
    );

    // Next-state and beat update; start outranks any pending transfer.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        reps_d    = reps_q;
        idx_d     = idx_q;
        val_d     = val_q;
        valid_d   = valid_q;
        load_s    = 1'b0;
        advance_s = 1'b0;
        if (_start) begin
            load_s = 1'b1;
            reps_d = reps;
            r_d    = REP_ZERO;
            if (start_ok_s) begin
                state_d = RUN;
                valid_d = 1'b1;
                val_d   = base;
                idx_d   = REP_ZERO;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end else if ((state_q == RUN) && xfer_s) begin
            if (!last_rep_s) begin
                r_d   = r_q + REP_ONE;
                idx_d = r_q + REP_ONE;
            end else if (nxt_ok_s) begin
                advance_s = 1'b1;
                r_d       = REP_ZERO;
                idx_d     = REP_ZERO;
                val_d     = nxt_s;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
        done_d = (state_d == IDLE);
    end

`ifdef REPEAT_RANGE_GEN_LAST_EN
    // Final-beat flag for the beat being presented next.
    always_comb begin
        last_d = last_q;
        if (_start) begin
            last_d = start_ok_s && (reps == REP_ONE) && !nxt_ok_s;
        end else if ((state_q == RUN) && xfer_s) begin
            if (!last_rep_s) begin
                last_d = ((r_q + REP_ONE) == (reps_q - REP_ONE)) && !nxt_ok_s;
            end else if (nxt_ok_s) begin
                last_d = (reps_q == REP_ONE) && !nxt2_ok_s;
            end else begin
                last_d = 1'b0;
            end
        end else begin
            last_d = last_q;
        end
    end

    // Final-beat register.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            last_q <= RST_LAST;
        end else begin
            last_q <= last_d;
        end
    end

    assign _last = last_q;
`endif

    // State, rep counter and output beat registers.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q <= IDLE;
            r_q     <= REP_ZERO;
            reps_q  <= REP_ZERO;
            idx_q   <= REP_ZERO;
            val_q   <= {WIDTH{1'b0}};
            valid_q <= RST_VALID;
            done_q  <= RST_DONE;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            reps_q  <= reps_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign _valid = valid_q;
    assign _done  = done_q;
    assign _0     = val_q;
    assign _1     = idx_q;

endmodule

// File: tb/tb_repeat_range_gen.sv
// Scoreboard bench for repeat_range_gen (32-bit instance plus an 8-bit overflow instance).
module tb_repeat_range_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, ready_a, valid_a, done_a;
    logic signed [31:0] base_a, limit_a, step_a, o0_a;
    logic [7:0] reps_a, o1_a;
    logic start_b, ready_b, valid_b, done_b;
    logic signed [7:0] base_b, limit_b, step_b, o0_b;
    logic [7:0] reps_b, o1_b;
`ifdef REPEAT_RANGE_GEN_LAST_EN
    logic last_a, last_b;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  r;
        logic        l;
    } beat_t;
    beat_t exp_q[$];

    repeat_range_gen #(.WIDTH(32), .REP_W(8)) dut_a (
        ._clock(clk), ._reset(rst), ._start(start_a),
        .base(base_a), .limit(limit_a), .step(step_a), .reps(reps_a),
        ._ready(ready_a), ._valid(valid_a), ._done(done_a), ._0(o0_a), ._1(o1_a)
`ifdef REPEAT_RANGE_GEN_LAST_EN
        , ._last(last_a)
`endif
    );

    repeat_range_gen #(.WIDTH(8), .REP_W(8)) dut_b (
        ._clock(clk), ._reset(rst), ._start(start_b),
        .base(base_b), .limit(limit_b), .step(step_b), .reps(reps_b),
        ._ready(ready_b), ._valid(valid_b), ._done(done_b), ._0(o0_b), ._1(o1_b)
`ifdef REPEAT_RANGE_GEN_LAST_EN
        , ._last(last_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: walk the range with 64-bit arithmetic, stop on bound or w-bit overflow.
    task automatic model(input longint b, input longint l, input longint s, input int r, input int w);
        longint vals[$];
        longint x;
        longint lo;
        longint hi;
        beat_t bt;
        x  = b;
        lo = -(longint'(1) <<< (w - 1));
        hi = (longint'(1) <<< (w - 1)) - 1;
        while (((s > 0 && x < l) || (s < 0 && x > l)) && x >= lo && x <= hi && vals.size() < 1000) begin
            vals.push_back(x);
            x += s;
        end
        if (r > 0) begin
            foreach (vals[j]) begin
                for (int k = 0; k < r; k++) begin
                    bt.v = 32'(vals[j]);
                    bt.r = 8'(k);
                    bt.l = (j == vals.size() - 1) && (k == r - 1);
                    exp_q.push_back(bt);
                end
            end
        end
    endtask

    task automatic run_a(input longint b, input longint l, input longint s, input int r,
                         input int mode, input string tag);
        int cyc;
        beat_t bt;
        model(b, l, s, r, 32);
        @(posedge clk); #1;
        base_a  = 32'(b);
        limit_a = 32'(l);
        step_a  = 32'(s);
        reps_a  = 8'(r);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        if (exp_q.size() > 0) check({tag, "_done_low"}, 32'(done_a), 32'd0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            ready_a = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            #4;
            bt = exp_q[0];
            check({tag, "_valid"}, 32'(valid_a), 32'd1);
            check({tag, "_0"}, o0_a, bt.v);
            check({tag, "_1"}, 32'(o1_a), 32'(bt.r));
`ifdef REPEAT_RANGE_GEN_LAST_EN
            check({tag, "_last"}, 32'(last_a), 32'(bt.l));
`endif
            if (ready_a) void'(exp_q.pop_front());
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() > 0) begin
            check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        check({tag, "_end_valid"}, 32'(valid_a), 32'd0);
        check({tag, "_end_done"}, 32'(done_a), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; ready_a = 1'b0; base_a = 32'sd0; limit_a = 32'sd0; step_a = 32'sd0; reps_a = 8'd0;
        start_b = 1'b0; ready_b = 1'b0; base_b = 8'sd0; limit_b = 8'sd0; step_b = 8'sd0; reps_b = 8'd0;
        #2;
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd1);
        check("rst_0", o0_a, 32'd0);
        check("rst_1", 32'(o1_a), 32'd0);
        check("rst_b_done", 32'(done_b), 32'd1);
`ifdef REPEAT_RANGE_GEN_LAST_EN
        check("rst_last", 32'(last_a), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        run_a(0, 10, 2, 2, 0, "basic");
        run_a(5, 0, -2, 1, 0, "neg_step");
        run_a(3, 3, 1, 2, 0, "empty_eq");
        run_a(0, 10, 0, 2, 0, "empty_step0");
        run_a(0, 10, 1, 0, 0, "empty_reps0");
        run_a(0, 4, 1, 3, 1, "backpressure");
        run_a(2147483000, 2147483647, 600, 1, 0, "ovf_pos32");
        run_a(-2147483000, -2147483647, -600, 2, 0, "ovf_neg32");

        // Restart while a beat is pending and unconsumed.
        @(posedge clk); #1;
        base_a = 32'sd0; limit_a = 32'sd100; step_a = 32'sd1; reps_a = 8'd2;
        ready_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("pre_restart_valid", 32'(valid_a), 32'd1);
        run_a(7, 9, 1, 1, 0, "restart_run");

        // 8-bit overflow: 0, 100, then stop (no wrap to -56).
        @(posedge clk); #1;
        base_b = 8'sd0; limit_b = 8'sd127; step_b = 8'sd100; reps_b = 8'd1;
        ready_b = 1'b1; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        #4;
        check("ovf8_valid0", 32'(valid_b), 32'd1);
        check("ovf8_beat0", 32'(o0_b), 32'd0);
`ifdef REPEAT_RANGE_GEN_LAST_EN
        check("ovf8_last0", 32'(last_b), 32'd0);
`endif
        @(posedge clk); #1; #4;
        check("ovf8_valid1", 32'(valid_b), 32'd1);
        check("ovf8_beat1", 32'(o0_b), 32'd100);
`ifdef REPEAT_RANGE_GEN_LAST_EN
        check("ovf8_last1", 32'(last_b), 32'd1);
`endif
        @(posedge clk); #1;
        check("ovf8_end_valid", 32'(valid_b), 32'd0);
        check("ovf8_end_done", 32'(done_b), 32'd1);

        // Asynchronous reset mid-run, then a fresh start.
        @(posedge clk); #1;
        base_a = 32'sd0; limit_a = 32'sd100; step_a = 32'sd1; reps_a = 8'd1;
        ready_a = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_run_0", o0_a, 32'd2);
        check("mid_run_done", 32'(done_a), 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(valid_a), 32'd0);
        check("async_rst_done", 32'(done_a), 32'd1);
        check("async_rst_0", o0_a, 32'd0);
        #1;
        rst = 1'b0;
        run_a(1, 3, 1, 1, 0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/repeat_range_gen.md
Name: repeat_range_gen

Overview:
- Parametrised hardware generator for a Python-style `range(base, limit, step)` that yields each value `reps` times.
- Generalises the fixed "yield i twice" generator: configurable data width, runtime repeat count, negative steps, full throughput and overflow-safe termination.
- Sits in the function-call library as a leaf generator. It is instantiated by generated caller modules and uses the standard `_start`/`_ready`/`_valid`/`_done` protocol.

Parameters:
- WIDTH, 32: signed width of base/limit/step/_0.
- REP_W, 8: unsigned width of the `reps` input and the `_1` output.

Ports:
- _clock  in  1  single clock; all logic on posedge.
- _reset  in  1  asynchronous, active-high reset.
- _start  in  1  one-cycle pulse; captures inputs and starts generation.
- base  in  WIDTH  signed start value.
- limit  in  WIDTH  signed exclusive bound.
- step  in  WIDTH  signed increment.
- reps  in  REP_W  unsigned yields per value.
- _ready  in  1  consumer can accept a beat.
- _valid  out  1  _0/_1 hold a valid beat.
- _done  out  1  high while idle / sequence exhausted.
- _0  out  WIDTH  current range value.
- _1  out  REP_W  repetition index of the current beat, counting 0..reps-1.

Behaviour:
- Reset (async, immediate): state=IDLE, _done=1, _valid=0, _0=0, _1=0. Reset dominates _start. Reset mid-run abandons the sequence with no further beats.
- States: IDLE, RUN.
- Registers: cursor i, rep counter r, captured limit/step/reps.
- in_range(x) is evaluated in WIDTH+1 bits:
  - step>0: x<limit.
  - step<0: x>limit.
  - step==0: false. The sequence is empty, by decision (Python raises instead).
- Empty sequence: reps==0 or !in_range(base).
- Start at edge N:
  - Inputs are captured.
  - If the sequence is non-empty: RUN, _valid=1, _0=base, _1=0, _done=0 after edge N.
  - If empty: stay/enter IDLE, _valid=0, _done=1.
  - _start during RUN restarts immediately; any unconsumed beat is dropped.
- Transfer: a beat transfers on a posedge with _valid&&_ready.
  - No transfer: _0/_1/_valid hold, whatever the state.
- On transfer in RUN:
  - If r<reps-1: r+=1, _1=r+1, _0 unchanged.
  - Else compute nxt=i+step in WIDTH+1 bits.
    - If in_range(nxt) and nxt is representable in WIDTH: i=nxt, r=0, _0=nxt, _1=0.
    - Otherwise: IDLE, _valid=0, _done=1.
- Throughput: one beat per cycle while _ready is held high; no bubbles between values.
- Overflow: a next value outside signed WIDTH terminates the sequence and never wraps.
- IDLE: _valid=0, _done=1; _ready is ignored.

Optional Feature:
- Macro: REPEAT_RANGE_GEN_LAST_EN.
- Defined: adds output port _last (1 bit), reset 0.
  - _last is high alongside _valid on the final beat of the sequence: r==reps-1 and the next value is out of range or overflows.
  - It is registered with _0/_1 and holds under backpressure.
- Undefined: no _last port and no lookahead logic.
- Beat sequence and timing are identical in both builds.

Decomposition:
- Package repeat_range_gen_pkg:
  - State enum (IDLE, RUN).
  - Localparams for the reset values.
  - An in_range function parametrised by width through a signed WIDTH+1 argument.
- Sub-module range_cursor:
  - Holds i and the captured limit/step.
  - Provides load/advance controls plus combinational nxt_in_range and cur_in_range.
  - Reusable by later range-style generators.
- The top level holds the handshake, the rep counter and the FSM.

Test Plan:
- Basic: WIDTH=32, (0,10,2), reps=2, _ready=1.
  - Beats _0: 0,0,2,2,4,4,6,6,8,8; _1: 0,1 repeating.
  - Ten consecutive cycles, then _valid=0, _done=1.
- Negative step: (5,0,-2), reps=1 → 5,3,1, then done.
- Empty cases: (3,3,1,r=2), (0,10,0,r=2) and (0,10,1,r=0) → no _valid; _done stays 1 the cycle after _start.
- Backpressure: (0,4,1), reps=3, _ready toggling 1,0,0,1,…
  - Output sequence is exactly 0,0,0,1,1,1,2,2,2,3,3,3.
  - _0/_1 are stable while _ready=0.
- Overflow: WIDTH=8, (0,127,100), reps=1 → 0,100, then done. There must be no wrap to -56.
- Reset/restart:
  - Assert _reset asynchronously mid-run: _valid and _done change before the next edge.
  - _start again with (1,3,1,r=1) → 1,2, with _last high on the 2 when REPEAT_RANGE_GEN_LAST_EN is defined.
